dmem_stage_unit: RTL
====================

Name: dmem_stage_unit

Overview:
- Parametrised, clocked successor to the SEQ memory stage. Performs the Y86-64 data-memory access selected by icode.
- Uses a start/done handshake with a configurable access latency, and range/alignment error reporting that feeds the processor status logic.
- Sits between execute (valA/valE/valP) and write-back (valM).
- Owns the data memory array.

Parameters:
- DATA_W, 64, data word width in bits; must be 64 for Y86-64 operation.
- DEPTH, 1024, number of 8-byte words in the data memory.
- ADDR_W, 64, width of the valA/valE address operands.
- LATENCY, 1, cycles spent in ACCESS state; legal values are >=1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- icode  input  4  instruction code of the request.
- valA  input  ADDR_W  source data, or address for ret/popq.
- valE  input  ADDR_W  address for rmmovq/mrmovq/call/pushq.
- valP  input  DATA_W  return address written by call.
- busy  output  1  high in any non-IDLE state.
- done  output  1  one-cycle completion pulse.
- valM  output  DATA_W  read data; valid with done, held until the next done.
- dmem_error  output  1  address fault; valid with done, held until the next done.

Behaviour:
- Reset state: all outputs are 0 (busy, done, valM, dmem_error); FSM in IDLE; latency counter 0. Memory array contents are not reset.
- Op decode, captured in IDLE when start=1:
  - write valA @ valE: 4 rmmovq, A pushq
  - write valP @ valE: 8 call
  - read @ valE: 5 mrmovq
  - read @ valA: 9 ret, B popq
  - no memory operation: all other icodes
- Byte address to word index: index = addr >> 3. The address is in range iff addr < DEPTH*8.
- FSM states and transitions:
  - IDLE, start=1 with a memory op: capture icode, address and data; clear counter; go to ACCESS.
  - IDLE, start=1 with a non-memory op: go to RESP; valM=0, dmem_error=0.
  - ACCESS: increment counter each cycle. On the cycle where counter==LATENCY-1, perform the access at the clock edge that leaves ACCESS, then go to RESP.
    - A write updates the array only if the address is valid.
    - A read loads valM with the array word, or with 0 if the address is invalid.
    - dmem_error is set for an invalid address.
  - RESP: done=1 for exactly one cycle; go to IDLE.
- Latency from the start edge to done high:
  - memory ops: LATENCY+1 cycles
  - non-memory ops: 1 cycle
  - Back-to-back throughput: one request per LATENCY+2 cycles for memory ops.
- start outside IDLE is ignored; inputs are not re-sampled.
- Input operands may change after the capture cycle with no effect on the operation in flight.
- A faulting write never modifies the array.
- A read returns data as of the access edge; a previous write to the same word is visible.
- Reset asserted mid-operation aborts immediately. A write not yet performed is discarded; a write already performed persists. Outputs return to their reset values.
- Address arithmetic is unsigned. A 64-bit address at or above DEPTH*8, including a huge value after stack wrap, faults. No wrap into the array.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: an address with addr[2:0]!=0 is invalid. It sets dmem_error, suppresses the write, and returns valM=0.
- Undefined: addr[2:0] is ignored and the access uses addr>>3. Only the range check can raise dmem_error.

Test Plan:
- rmmovq (icode 4), valE=0x40, valA=0xDEADBEEF, then mrmovq (icode 5), valE=0x40 -> valM=0xDEADBEEF, dmem_error=0, done at start+LATENCY+1.
- call (icode 8), valE=0x1F8, valP=0x123, then ret (icode 9), valA=0x1F8 -> valM=0x123.
- pushq (icode A), valE=DEPTH*8, valA=0x55 -> dmem_error=1; a follow-up read at valE=DEPTH*8-8 returns the prior contents unchanged.
- OPq (icode 6) with start=1 -> done on the next cycle, valM=0, busy never asserted beyond RESP.
- With DMEM_ALIGN_CHECK_EN defined, mrmovq (icode 5), valE=0x43 -> dmem_error=1, valM=0. With it undefined, the same request reads word 8.
- LATENCY=3: assert start during ACCESS -> it is ignored. Drop rst_n in the second ACCESS cycle of an rmmovq -> outputs return to 0 and a later read shows no write occurred.

Source files
------------

// File: rtl/dmem_stage_unit.sv
// Clocked Y86-64 data-memory stage: start/done handshake, LATENCY-cycle access, range fault reporting.
// Optional macro DMEM_ALIGN_CHECK_EN also faults on addresses that are not 8-byte aligned.
module dmem_stage_unit #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 64,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        icode,
  input  logic [ADDR_W-1:0] valA,
  input  logic [ADDR_W-1:0] valE,
  input  logic [DATA_W-1:0] valP,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] valM,
  output logic              dmem_error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH) << 3;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] valm_q, valm_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              req_mem, req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              addr_ok, last_cycle;
  logic [IDX_W-1:0]  idx;

  always_comb begin
    req_mem  = 1'b0;
    req_wr   = 1'b0;
    req_addr = valE;
    req_data = DATA_W'(valA);
    case (icode)
      4'h4, 4'hA: begin req_mem = 1'b1; req_wr = 1'b1; end
      4'h8:       begin req_mem = 1'b1; req_wr = 1'b1; req_data = valP; end
      4'h5:       req_mem = 1'b1;
      4'h9, 4'hB: begin req_mem = 1'b1; req_addr = valA; end
      default:    ;
    endcase
  end

  // Unsigned compare: wrapped stack pointers land far above the limit and fault.
`ifdef DMEM_ALIGN_CHECK_EN
  assign addr_ok = (addr_q < ADDR_LIMIT) && (addr_q[2:0] == 3'b000);
`else
  assign addr_ok = (addr_q < ADDR_LIMIT);
`endif

  assign idx        = addr_q[IDX_W+2:3];
  assign last_cycle = (state_q == S_ACCESS) && (cnt_q == CNT_W'(LATENCY - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valm_d  = valm_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (req_mem) begin
            wr_d    = req_wr;
            addr_d  = req_addr;
            wdata_d = req_data;
            cnt_d   = '0;
            state_d = S_ACCESS;
          end else begin
            valm_d  = '0;
            err_d   = 1'b0;
            state_d = S_RESP;
          end
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (last_cycle) begin
          err_d   = !addr_ok;
          valm_d  = (!wr_q && addr_ok) ? mem[idx] : '0;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valm_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valm_q  <= valm_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset; rst_n gating keeps an aborted write from landing.
  always_ff @(posedge clk) begin
    if (rst_n && last_cycle && wr_q && addr_ok) begin
      mem[idx] <= wdata_q;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_RESP);
  assign valM       = valm_q;
  assign dmem_error = err_q;

endmodule
